// File: rtl/game_pkg.sv
// Shared game-wide constants and types: screen geometry, colour palette and
// the rect_plotter state encoding.
package game_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef logic [2:0] colour_t;

    localparam colour_t BLACK = 3'b000;
    localparam colour_t WHITE = 3'b111;
    localparam colour_t BLUE  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } rect_state_t;

endpackage

// File: rtl/rect_scan_counter.sv
// Nested column/row counter for the rectangle sweep. It presents the coordinate
// that becomes current at the next edge, plus edge flags for that coordinate.
module rect_scan_counter
    import game_pkg::*;
#(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           en,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    output logic [X_W-1:0] nxt_cx,
    output logic [Y_W-1:0] nxt_cy,
    output logic           first_col,
    output logic           last_col,
    output logic           first_row,
    output logic           last_row,
    output logic           last_pixel
);

    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic [X_W-1:0] w_last;
    logic [Y_W-1:0] h_last;
    logic           cur_last_col;
    logic           cur_last_row;

    assign w_last       = w - X_W'(1);
    assign h_last       = h - Y_W'(1);
    assign cur_last_col = (cx == w_last);
    assign cur_last_row = (cy == h_last);
    assign last_pixel   = cur_last_col && cur_last_row;

    always_comb begin
        nxt_cx = cx;
        nxt_cy = cy;
        if (load) begin
            nxt_cx = '0;
            nxt_cy = '0;
        end else if (en) begin
            if (cur_last_col) begin
                nxt_cx = '0;
                nxt_cy = cy + Y_W'(1);
            end else begin
                nxt_cx = cx + X_W'(1);
            end
        end
    end

    // Flags describe the pixel about to be registered, not the current one.
    assign first_col = (nxt_cx == '0);
    assign last_col  = (nxt_cx == w_last);
    assign first_row = (nxt_cy == '0);
    assign last_row  = (nxt_cy == h_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cx <= '0;
            cy <= '0;
        end else if (load || en) begin
            cx <= nxt_cx;
            cy <= nxt_cy;
        end
    end

endmodule

// File: rtl/rect_plotter.sv
// Rectangle sweep engine feeding the vga_adapter, one pixel per clock.
// Define RECT_CLIP_EN to suppress plots that fall outside the visible screen.
module rect_plotter
    import game_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = game_pkg::SCREEN_W,
    parameter int SCREEN_H = game_pkg::SCREEN_H
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [X_W-1:0]      req_x,
    input  logic [Y_W-1:0]      req_y,
    input  logic [X_W-1:0]      req_w,
    input  logic [Y_W-1:0]      req_h,
    input  logic [COLOUR_W-1:0] req_colour,
    input  logic                req_fill,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

`ifdef RECT_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    rect_state_t         state, state_n;
    logic [X_W-1:0]      x0_q, w_q;
    logic [Y_W-1:0]      y0_q, h_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                fill_q;

    logic                in_idle, accept, req_empty;
    logic                cnt_load, cnt_en, emit;
    logic [X_W-1:0]      x0_sel, cnt_w, nxt_cx;
    logic [Y_W-1:0]      y0_sel, cnt_h, nxt_cy;
    logic [COLOUR_W-1:0] colour_sel;
    logic                fill_sel;
    logic                first_col, last_col, first_row, last_row, last_pixel;
    logic [X_W:0]        sum_x;
    logic [Y_W:0]        sum_y;
    logic                in_screen, pix_on, plot_n;

    // Handshake: a request transfers on any edge where req_valid && req_ready.
    assign in_idle   = (state == ST_IDLE);
    assign req_ready = in_idle && !reset;
    assign accept    = req_valid && req_ready;
    assign req_empty = (req_w == '0) || (req_h == '0);

    // In IDLE the first pixel is built straight from the request fields.
    assign x0_sel     = in_idle ? req_x      : x0_q;
    assign y0_sel     = in_idle ? req_y      : y0_q;
    assign cnt_w      = in_idle ? req_w      : w_q;
    assign cnt_h      = in_idle ? req_h      : h_q;
    assign colour_sel = in_idle ? req_colour : colour_q;
    assign fill_sel   = in_idle ? req_fill   : fill_q;

    rect_scan_counter #(.X_W(X_W), .Y_W(Y_W)) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .en         (cnt_en),
        .w          (cnt_w),
        .h          (cnt_h),
        .nxt_cx     (nxt_cx),
        .nxt_cy     (nxt_cy),
        .first_col  (first_col),
        .last_col   (last_col),
        .first_row  (first_row),
        .last_row   (last_row),
        .last_pixel (last_pixel)
    );

    assign sum_x     = {1'b0, x0_sel} + {1'b0, nxt_cx};
    assign sum_y     = {1'b0, y0_sel} + {1'b0, nxt_cy};
    assign in_screen = (int'(sum_x) < SCREEN_W) && (int'(sum_y) < SCREEN_H);
    assign pix_on    = !CLIP_EN || in_screen;
    assign plot_n    = emit && pix_on &&
                       (fill_sel || first_col || last_col || first_row || last_row);

    always_comb begin
        state_n  = state;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        emit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    if (req_empty) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_SCAN;
                        emit    = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (last_pixel) begin
                    state_n = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                    emit   = 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            colour_q <= '0;
            fill_q   <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            plot     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                x0_q     <= req_x;
                y0_q     <= req_y;
                w_q      <= req_w;
                h_q      <= req_h;
                colour_q <= req_colour;
                fill_q   <= req_fill;
            end
            if (emit) begin
                x      <= sum_x[X_W-1:0];
                y      <= sum_y[Y_W-1:0];
                colour <= colour_sel;
            end
            plot <= plot_n;
            busy <= (state_n != ST_IDLE);
            done <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_rect_plotter.sv
// Scoreboard bench for rect_plotter: a geometric reference model queues the
// expected plotted pixels, and a monitor checks every plot/done the DUT emits.
module tb_rect_plotter;
    import game_pkg::*;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;
    localparam int PW  = X_W + Y_W + C_W;

    logic           clk, reset;
    logic           req_valid, req_ready;
    logic [X_W-1:0] req_x, req_w;
    logic [Y_W-1:0] req_y, req_h;
    logic [C_W-1:0] req_colour;
    logic           req_fill;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
    logic           plot, busy, done;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [PW-1:0] exp_q[$];

    rect_plotter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
        .req_fill   (req_fill),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    // Clock / timeout
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got no end required end");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: every pixel of the rectangle, in raster order
    task automatic push_model(input int x0, input int y0, input int w, input int h,
                              input int c, input bit f);
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < w; k++) begin
                int px, py;
                bit on;
                logic [X_W-1:0] ex;
                logic [Y_W-1:0] ey;
                logic [C_W-1:0] ec;
                px = x0 + k;
                py = y0 + r;
                on = f || r == 0 || r == h - 1 || k == 0 || k == w - 1;
`ifdef RECT_CLIP_EN
                if (px >= SCREEN_W || py >= SCREEN_H) on = 1'b0;
`else
                px = px % 256;
                py = py % 128;
`endif
                if (on) begin
                    ex = px[X_W-1:0];
                    ey = py[Y_W-1:0];
                    ec = c[C_W-1:0];
                    exp_q.push_back({ex, ey, ec});
                end
            end
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (plot) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_plot: got (%0d,%0d,c%0d) expected no plot", x, y, colour);
                end else begin
                    logic [PW-1:0] e;
                    e = exp_q.pop_front();
                    if ({x, y, colour} !== e) begin
                        errors++;
                        $display("FAIL pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                                 x, y, colour, e[PW-1 -: X_W], e[C_W +: Y_W], e[C_W-1:0]);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                chk("pixels_left_at_done", exp_q.size(), 0);
            end
        end
    end

    // Driver tasks
    task automatic issue(input int x0, input int y0, input int w, input int h,
                         input int c, input bit f, input bit hold);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_issue", int'(req_ready), 1);
        req_x      = x0[X_W-1:0];
        req_y      = y0[Y_W-1:0];
        req_w      = w[X_W-1:0];
        req_h      = h[Y_W-1:0];
        req_colour = c[C_W-1:0];
        req_fill   = f;
        req_valid  = 1'b1;
        push_model(x0, y0, w, h, c, f);
        @(posedge clk);
        if (!hold) begin
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int w, input int h, input string name);
        int  k = 0;
        int  busy_cnt = 0;
        int  exp_k;
        bit  seen = 1'b0;
        exp_k = (w == 0 || h == 0) ? 1 : w * h + 1;
        while (!seen && k < 3000) begin
            @(negedge clk);
            k++;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
        end
        chk({name, "_done_latency"}, seen ? k : -1, exp_k);
        chk({name, "_busy_cycles"}, busy_cnt, exp_k);
        exp_done++;
        @(negedge clk);
        chk({name, "_ready_after_done"}, int'(req_ready), 1);
        chk({name, "_done_one_cycle"}, int'(done), 0);
    endtask

    task automatic run(input int x0, input int y0, input int w, input int h,
                       input int c, input bit f, input string name);
        issue(x0, y0, w, h, c, f, 1'b0);
        wait_done(w, h, name);
    endtask

    initial begin
        int dc;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_x      = '0;
        req_y      = '0;
        req_w      = '0;
        req_h      = '0;
        req_colour = '0;
        req_fill   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", int'(req_ready), 0);
        chk("reset_plot", int'(plot), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", int'(req_ready), 1);

        run(10, 20, 3, 2, 3'b100, 1'b1, "fill_3x2");
        run(0, 0, 4, 3, 3'b111, 1'b0, "outline_4x3");
        run(5, 5, 0, 5, 3'b010, 1'b1, "empty_w0");
        run(5, 5, 3, 0, 3'b010, 1'b0, "empty_h0");
        run(158, 0, 4, 1, 3'b001, 1'b1, "right_edge");
        run(2, 117, 2, 5, 3'b110, 1'b0, "bottom_edge");

        // Abort a 5x5 fill after its second pixel
        issue(20, 30, 5, 5, 3'b011, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_plot", int'(plot), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ready", int'(req_ready), 0);
        chk("abort_xy", int'({x, y, colour}), 0);
        dc = done_cnt;
        repeat (3) @(negedge clk);
        exp_q.delete();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt, dc);
        run(7, 7, 1, 1, 3'b101, 1'b1, "after_abort_1x1");

        // Valid held across two requests
        issue(40, 40, 3, 3, 3'b001, 1'b0, 1'b1);
        #1;
        req_x      = 8'd60;
        req_y      = 7'd50;
        req_w      = 8'd2;
        req_h      = 7'd2;
        req_colour = 3'b110;
        req_fill   = 1'b1;
        wait_done(3, 3, "held_first");
        push_model(60, 50, 2, 2, 3'b110, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_done(2, 2, "held_second");

        for (int i = 0; i < 25; i++) begin
            int rx, ry, rw, rh, rc;
            bit rf;
            rx = $urandom_range(0, 170);
            ry = $urandom_range(0, 125);
            rw = $urandom_range(0, 8);
            rh = $urandom_range(0, 6);
            rc = $urandom_range(0, 7);
            rf = 1'($urandom_range(0, 1));
            run(rx, ry, rw, rh, rc, rf, "random");
        end

        repeat (3) @(negedge clk);
        chk("done_pulse_count", done_cnt, exp_done);
        chk("queue_empty_at_end", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
